// File: rtl/mux8to1_pkg.sv
// Shared constants for the registered 8-to-1 multiplexer.
package mux8to1_pkg;

    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic [SEL_W-1:0] SEL_IN0 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_IN1 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_IN2 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_IN3 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_IN4 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_IN5 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_IN6 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_IN7 = 3'd7;

endpackage

// File: rtl/mux8to1_16bit.sv
// Registered 8-to-1 multiplexer with load enable and a valid flag.
// Optional even-parity output when MUX8TO1_PARITY_EN is defined.
module mux8to1_16bit
    import mux8to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
`ifdef MUX8TO1_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] selected;

    // All eight codes are decoded explicitly, so no default arm is needed.
    always_comb begin
        selected = in0;
        case (sel)
            SEL_IN0: selected = in0;
            SEL_IN1: selected = in1;
            SEL_IN2: selected = in2;
            SEL_IN3: selected = in3;
            SEL_IN4: selected = in4;
            SEL_IN5: selected = in5;
            SEL_IN6: selected = in6;
            SEL_IN7: selected = in7;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                out <= selected;
            end
        end
    end

`ifdef MUX8TO1_PARITY_EN
    assign out_parity = ^out;
`endif

endmodule

// File: tb/tb_mux8to1_16bit.sv
// Directed self-checking bench for mux8to1_16bit.
// Parity checks are compiled in only when MUX8TO1_PARITY_EN is defined.
module tb_mux8to1_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic [2:0]  sel;
    logic        en;
    logic [15:0] out;
    logic        out_valid;
`ifdef MUX8TO1_PARITY_EN
    logic        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sweep_exp [8];

    mux8to1_16bit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .in5       (in5),
        .in6       (in6),
        .in7       (in7),
        .sel       (sel),
        .en        (en),
        .out       (out),
`ifdef MUX8TO1_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sweep_exp[0] = 16'hFFFF; sweep_exp[1] = 16'h0000;
        sweep_exp[2] = 16'hFE00; sweep_exp[3] = 16'h01FF;
        sweep_exp[4] = 16'h11FF; sweep_exp[5] = 16'h01F7;
        sweep_exp[6] = 16'h41F7; sweep_exp[7] = 16'hC1FF;

        // Reset with arbitrary inputs, observed before any clock edge.
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 3'd5;
        in0 = 16'h1234; in1 = 16'h5678; in2 = 16'h9ABC; in3 = 16'hDEF0;
        in4 = 16'hAAAA; in5 = 16'h5555; in6 = 16'h0F0F; in7 = 16'hF0F0;
        #2;
        check_output("reset_out", 32'(out), 32'h0000);
        check_output("reset_valid", 32'(out_valid), 32'h0);

        tick();
        check_output("reset_en_ignored_out", 32'(out), 32'h0000);
        check_output("reset_en_ignored_valid", 32'(out_valid), 32'h0);

        // Release reset; with en low the output must stay at zero.
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check_output("post_reset_idle_out", 32'(out), 32'h0000);
        check_output("post_reset_idle_valid", 32'(out_valid), 32'h0);

        in0 = 16'hFFFF; in1 = 16'h0000; in2 = 16'hFE00; in3 = 16'h01FF;
        in4 = 16'h11FF; in5 = 16'h01F7; in6 = 16'h41F7; in7 = 16'hC1FF;
        en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            tick();
            check_output($sformatf("sweep_out_%0d", i), 32'(out), 32'(sweep_exp[i]));
            check_output($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'h1);
`ifdef MUX8TO1_PARITY_EN
            check_output($sformatf("sweep_parity_%0d", i), 32'(out_parity), 32'(^sweep_exp[i]));
`endif
        end

        // Hold: en low must freeze out even though sel changes.
        sel = 3'd3;
        tick();
        check_output("hold_load_out", 32'(out), 32'h01FF);
        en  = 1'b0;
        sel = 3'd0;
        tick();
        check_output("hold_out", 32'(out), 32'h01FF);
        check_output("hold_valid", 32'(out_valid), 32'h0);
        tick();
        check_output("hold_out_2", 32'(out), 32'h01FF);

        // Repeat select, then data change on the held selection.
        en  = 1'b1;
        sel = 3'd7;
        tick();
        check_output("repeat_out_1", 32'(out), 32'hC1FF);
        tick();
        check_output("repeat_out_2", 32'(out), 32'hC1FF);
        check_output("repeat_valid", 32'(out_valid), 32'h1);
        in7 = 16'h0001;
        tick();
        check_output("repeat_new_data", 32'(out), 32'h0001);

        // Asynchronous reset between edges while out holds 41F7.
        sel = 3'd6;
        tick();
        check_output("pre_reset_out", 32'(out), 32'h41F7);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_out", 32'(out), 32'h0000);
        check_output("async_reset_valid", 32'(out_valid), 32'h0);
        tick();
        check_output("async_reset_held_out", 32'(out), 32'h0000);
        #2;
        rst_n = 1'b1;
        sel   = 3'd2;
        tick();
        check_output("after_reset_load", 32'(out), 32'hFE00);
        check_output("after_reset_valid", 32'(out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
